// File: rtl/regfile_pkg.sv
// Shared defaults, index type and register-index helpers for the register file and its scoreboard.
package regfile_pkg;

    localparam int N_DEF    = 64;
    localparam int NREG_DEF = 32;
    localparam int ZR_DEF   = 31;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0] reg_idx_t;

    function automatic logic is_zr(input int unsigned idx, input int unsigned zr);
        return idx == zr;
    endfunction

    // An index names real state only if it exists and is not the hardwired-zero register.
    function automatic logic idx_ok(input int unsigned idx, input int unsigned nreg,
                                    input int unsigned zr);
        return (idx < nreg) && !is_zr(idx, zr);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set when a producer issues, cleared by its writeback.
// Two registered lookup ports aligned with the register-file read data.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int ZR     = ZR_DEF,
    parameter int BYPASS = 1,
    parameter int AW     = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          busy1,
    output logic          busy2
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            busy1_q;
    logic            busy1_d;
    logic            busy2_q;
    logic            busy2_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en && idx_ok(32'(clr_idx), NREG, ZR)) begin
            busy_d[clr_idx] = 1'b0;
        end
        // Set is applied after clear so a new producer wins over a retiring one.
        if (set_en && idx_ok(32'(set_idx), NREG, ZR)) begin
            busy_d[set_idx] = 1'b1;
        end
    end

    always_comb begin
        busy1_d = 1'b0;
        busy2_d = 1'b0;
        if (idx_ok(32'(ra1), NREG, ZR)) begin
            busy1_d = (BYPASS != 0) ? busy_d[ra1] : busy_q[ra1];
        end
        if (idx_ok(32'(ra2), NREG, ZR)) begin
            busy2_d = (BYPASS != 0) ? busy_d[ra2] : busy_q[ra2];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q  <= '0;
            busy1_q <= 1'b0;
            busy2_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            busy1_q <= busy1_d;
            busy2_q <= busy2_d;
        end
    end

    assign busy1 = busy1_q;
    assign busy2 = busy2_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with hardwired-zero register, optional write->read
// bypass and a busy scoreboard for in-flight producers.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int ZR     = ZR_DEF,
    parameter int BYPASS = 1,
    parameter int AW     = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [N-1:0]  rd1,
    output logic [N-1:0]  rd2,
    output logic          busy1,
    output logic          busy2,
    input  logic          we3,
    input  logic [AW-1:0] wa3,
    input  logic [N-1:0]  wd3,
    input  logic          sb_set,
    input  logic [AW-1:0] sb_wa
);

    logic [N-1:0] mem_q [NREG];
    logic [N-1:0] mem_d [NREG];
    logic [N-1:0] rd1_q;
    logic [N-1:0] rd1_d;
    logic [N-1:0] rd2_q;
    logic [N-1:0] rd2_d;
    logic         wr_ok;

    always_comb begin
        wr_ok = we3 && idx_ok(32'(wa3), NREG, ZR);
        for (int i = 0; i < NREG; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_ok) begin
            mem_d[wa3] = wd3;
        end
    end

    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (idx_ok(32'(ra1), NREG, ZR)) begin
            rd1_d = (BYPASS != 0 && wr_ok && wa3 == ra1) ? wd3 : mem_q[ra1];
        end
        if (idx_ok(32'(ra2), NREG, ZR)) begin
            rd2_d = (BYPASS != 0 && wr_ok && wa3 == ra2) ? wd3 : mem_q[ra2];
        end
    end

    // Each register resets to its own index so post-reset reads are distinguishable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= (i == ZR) ? '0 : N'(i);
            end
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
        end
    end

    assign rd1 = rd1_q;
    assign rd2 = rd2_q;

    reg_scoreboard #(
        .NREG   (NREG),
        .ZR     (ZR),
        .BYPASS (BYPASS),
        .AW     (AW)
    ) u_scoreboard (
        .clk     (clk),
        .reset_n (reset_n),
        .set_en  (sb_set),
        .set_idx (sb_wa),
        .clr_en  (we3),
        .clr_idx (wa3),
        .ra1     (ra1),
        .ra2     (ra2),
        .busy1   (busy1),
        .busy2   (busy2)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: default register file with and without bypass, plus a 32x16, ZR=0 variant.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    reg_idx_t    ra1, ra2, wa3, sb_wa;
    logic        we3, sb_set;
    logic [63:0] wd3;
    logic [63:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        busy1_a, busy2_a, busy1_b, busy2_b;

    logic [3:0]  c_ra1, c_ra2, c_wa3, c_sb_wa;
    logic        c_we3, c_sb_set;
    logic [31:0] c_wd3, c_rd1, c_rd2;
    logic        c_busy1, c_busy2;

    int n_cmp = 0;
    int n_err = 0;

    regfile_sb #(.N(64), .NREG(32), .ZR(31), .BYPASS(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
        .busy1(busy1_a), .busy2(busy2_a), .we3(we3), .wa3(wa3), .wd3(wd3),
        .sb_set(sb_set), .sb_wa(sb_wa));

    regfile_sb #(.N(64), .NREG(32), .ZR(31), .BYPASS(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .busy1(busy1_b), .busy2(busy2_b), .we3(we3), .wa3(wa3), .wd3(wd3),
        .sb_set(sb_set), .sb_wa(sb_wa));

    regfile_sb #(.N(32), .NREG(16), .ZR(0), .BYPASS(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .ra1(c_ra1), .ra2(c_ra2), .rd1(c_rd1), .rd2(c_rd2),
        .busy1(c_busy1), .busy2(c_busy2), .we3(c_we3), .wa3(c_wa3), .wd3(c_wd3),
        .sb_set(c_sb_set), .sb_wa(c_sb_wa));

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t ra=%0d/%0d we3=%b wa3=%0d sb=%b:%0d | a rd=%h/%h bz=%b%b | b rd=%h/%h bz=%b%b | c rd=%h/%h bz=%b%b",
                 $time, ra1, ra2, we3, wa3, sb_set, sb_wa, rd1_a, rd2_a, busy1_a, busy2_a,
                 rd1_b, rd2_b, busy1_b, busy2_b, c_rd1, c_rd2, c_busy1, c_busy2);
    endtask

    task automatic idle();
        we3 = 1'b0; sb_set = 1'b0; c_we3 = 1'b0; c_sb_set = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ra1 = 5'd5; ra2 = 5'd31; wa3 = '0; wd3 = '0; sb_wa = '0;
        c_ra1 = 4'd5; c_ra2 = 4'd0; c_wa3 = '0; c_wd3 = '0; c_sb_wa = '0;
        idle();
        step(); step();
        n_cmp++; if (rd1_a !== 64'h0) begin n_err++; $display("FAIL rst_hold_rd1: got %h want %h", rd1_a, 64'h0); end
        n_cmp++; if (busy1_a !== 1'b0) begin n_err++; $display("FAIL rst_hold_busy1: got %b want 0", busy1_a); end
        reset_n = 1'b1;
        step();
        n_cmp++; if (rd1_a !== 64'h5) begin n_err++; $display("FAIL rst_rd1_a: got %h want %h", rd1_a, 64'h5); end
        n_cmp++; if (rd2_a !== 64'h0) begin n_err++; $display("FAIL rst_rd2_zr_a: got %h want %h", rd2_a, 64'h0); end
        n_cmp++; if ({busy1_a, busy2_a} !== 2'b00) begin n_err++; $display("FAIL rst_busy_a: got %b%b want 00", busy1_a, busy2_a); end
        n_cmp++; if (rd1_b !== 64'h5) begin n_err++; $display("FAIL rst_rd1_b: got %h want %h", rd1_b, 64'h5); end
        n_cmp++; if (c_rd1 !== 32'h5) begin n_err++; $display("FAIL rst_rd1_c: got %h want %h", c_rd1, 32'h5); end
        n_cmp++; if (c_rd2 !== 32'h0) begin n_err++; $display("FAIL rst_rd2_zr_c: got %h want %h", c_rd2, 32'h0); end
    endtask

    task automatic test_write();
        we3 = 1'b1; wa3 = 5'd7; wd3 = 64'hDEAD; ra1 = 5'd0; ra2 = 5'd0;
        step();
        idle(); ra1 = 5'd7;
        step();
        n_cmp++; if (rd1_a !== 64'hDEAD) begin n_err++; $display("FAIL wr_rd1_a: got %h want %h", rd1_a, 64'hDEAD); end
        n_cmp++; if (rd1_b !== 64'hDEAD) begin n_err++; $display("FAIL wr_rd1_b: got %h want %h", rd1_b, 64'hDEAD); end
        we3 = 1'b1; wa3 = 5'd31; wd3 = 64'hFF; ra2 = 5'd31;
        step();
        n_cmp++; if (rd2_a !== 64'h0) begin n_err++; $display("FAIL wr_zr_bypass_a: got %h want %h", rd2_a, 64'h0); end
        idle();
        step();
        n_cmp++; if (rd2_a !== 64'h0) begin n_err++; $display("FAIL wr_zr_a: got %h want %h", rd2_a, 64'h0); end
        n_cmp++; if (rd2_b !== 64'h0) begin n_err++; $display("FAIL wr_zr_b: got %h want %h", rd2_b, 64'h0); end
    endtask

    task automatic test_bypass();
        we3 = 1'b1; wa3 = 5'd3; wd3 = 64'h1234; ra1 = 5'd3; ra2 = 5'd3;
        step();
        n_cmp++; if (rd1_a !== 64'h1234) begin n_err++; $display("FAIL byp_rd1_a: got %h want %h", rd1_a, 64'h1234); end
        n_cmp++; if (rd2_a !== 64'h1234) begin n_err++; $display("FAIL byp_rd2_a: got %h want %h", rd2_a, 64'h1234); end
        n_cmp++; if (rd1_b !== 64'h3) begin n_err++; $display("FAIL nobyp_rd1_b: got %h want %h", rd1_b, 64'h3); end
        idle();
        step();
        n_cmp++; if (rd1_b !== 64'h1234) begin n_err++; $display("FAIL nobyp_next_b: got %h want %h", rd1_b, 64'h1234); end
        n_cmp++; if (rd1_a !== 64'h1234) begin n_err++; $display("FAIL byp_next_a: got %h want %h", rd1_a, 64'h1234); end
    endtask

    task automatic test_scoreboard();
        sb_set = 1'b1; sb_wa = 5'd9; ra1 = 5'd0;
        step();
        idle(); ra1 = 5'd9;
        step();
        n_cmp++; if (busy1_a !== 1'b1) begin n_err++; $display("FAIL sb_set_a: got %b want 1", busy1_a); end
        n_cmp++; if (busy1_b !== 1'b1) begin n_err++; $display("FAIL sb_set_b: got %b want 1", busy1_b); end
        we3 = 1'b1; wa3 = 5'd9; wd3 = 64'h99;
        step();
        n_cmp++; if ({busy1_a, rd1_a} !== {1'b0, 64'h99}) begin n_err++; $display("FAIL sb_clr_byp_a: got %b/%h want 0/%h", busy1_a, rd1_a, 64'h99); end
        n_cmp++; if ({busy1_b, rd1_b} !== {1'b1, 64'h9}) begin n_err++; $display("FAIL sb_clr_nobyp_b: got %b/%h want 1/%h", busy1_b, rd1_b, 64'h9); end
        idle();
        step();
        n_cmp++; if (busy1_a !== 1'b0) begin n_err++; $display("FAIL sb_clr_a: got %b want 0", busy1_a); end
        n_cmp++; if ({busy1_b, rd1_b} !== {1'b0, 64'h99}) begin n_err++; $display("FAIL sb_clr_b: got %b/%h want 0/%h", busy1_b, rd1_b, 64'h99); end
    endtask

    task automatic test_sb_collide();
        sb_set = 1'b1; sb_wa = 5'd4; we3 = 1'b1; wa3 = 5'd4; wd3 = 64'h44;
        step();
        wa3 = 5'd6; wd3 = 64'h66;
        step();
        idle(); ra1 = 5'd4; ra2 = 5'd6;
        step();
        n_cmp++; if ({busy1_a, busy2_a} !== 2'b10) begin n_err++; $display("FAIL coll_busy_a: got %b%b want 10", busy1_a, busy2_a); end
        n_cmp++; if ({busy1_b, busy2_b} !== 2'b10) begin n_err++; $display("FAIL coll_busy_b: got %b%b want 10", busy1_b, busy2_b); end
        n_cmp++; if (rd2_a !== 64'h66) begin n_err++; $display("FAIL coll_rd2_a: got %h want %h", rd2_a, 64'h66); end
        ra2 = 5'd4;
        step();
        n_cmp++; if ({busy1_a, busy2_a} !== 2'b11) begin n_err++; $display("FAIL same_busy_a: got %b%b want 11", busy1_a, busy2_a); end
        n_cmp++; if ({rd1_a, rd2_a} !== {64'h44, 64'h44}) begin n_err++; $display("FAIL same_rd_a: got %h/%h want 44/44", rd1_a, rd2_a); end
        sb_set = 1'b1; sb_wa = 5'd31; ra1 = 5'd31;
        step();
        idle();
        step();
        n_cmp++; if ({busy1_a, rd1_a} !== {1'b0, 64'h0}) begin n_err++; $display("FAIL sb_zr_a: got %b/%h want 0/0", busy1_a, rd1_a); end
    endtask

    task automatic test_async_reset();
        we3 = 1'b1; wa3 = 5'd2; wd3 = 64'hAA;
        step();
        idle(); sb_set = 1'b1; sb_wa = 5'd2;
        step();
        idle(); ra1 = 5'd2; ra2 = 5'd2;
        step();
        n_cmp++; if ({busy1_a, rd1_a} !== {1'b1, 64'hAA}) begin n_err++; $display("FAIL pre_rst_a: got %b/%h want 1/%h", busy1_a, rd1_a, 64'hAA); end
        we3 = 1'b1; wa3 = 5'd2; wd3 = 64'hBB;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if ({rd1_a, rd2_a} !== 128'h0) begin n_err++; $display("FAIL arst_rd_a: got %h/%h want 0/0", rd1_a, rd2_a); end
        n_cmp++; if ({busy1_a, busy2_a, busy1_b, busy2_b} !== 4'b0000) begin n_err++; $display("FAIL arst_busy: got %b%b%b%b want 0000", busy1_a, busy2_a, busy1_b, busy2_b); end
        #2 reset_n = 1'b1;
        idle(); ra2 = 5'd7;
        step();
        n_cmp++; if ({busy1_a, rd1_a} !== {1'b0, 64'h2}) begin n_err++; $display("FAIL post_rst_rd1_a: got %b/%h want 0/%h", busy1_a, rd1_a, 64'h2); end
        n_cmp++; if (rd2_a !== 64'h7) begin n_err++; $display("FAIL post_rst_rd2_a: got %h want %h", rd2_a, 64'h7); end
        n_cmp++; if ({busy1_b, rd1_b} !== {1'b0, 64'h2}) begin n_err++; $display("FAIL post_rst_rd1_b: got %b/%h want 0/%h", busy1_b, rd1_b, 64'h2); end
    endtask

    task automatic test_param_small();
        c_ra1 = 4'd5; c_ra2 = 4'd15;
        step();
        n_cmp++; if ({c_rd1, c_rd2} !== {32'h5, 32'hF}) begin n_err++; $display("FAIL c_rst_rd: got %h/%h want 5/f", c_rd1, c_rd2); end
        c_we3 = 1'b1; c_wa3 = 4'd7; c_wd3 = 32'hDEAD;
        step();
        idle(); c_ra1 = 4'd7;
        step();
        n_cmp++; if (c_rd1 !== 32'hDEAD) begin n_err++; $display("FAIL c_wr_rd1: got %h want %h", c_rd1, 32'hDEAD); end
        c_we3 = 1'b1; c_wa3 = 4'd0; c_wd3 = 32'hFF; c_ra2 = 4'd0;
        step();
        n_cmp++; if (c_rd2 !== 32'h0) begin n_err++; $display("FAIL c_wr_zr: got %h want 0", c_rd2); end
        c_wa3 = 4'd3; c_wd3 = 32'h1234; c_ra1 = 4'd3;
        step();
        n_cmp++; if (c_rd1 !== 32'h1234) begin n_err++; $display("FAIL c_byp: got %h want %h", c_rd1, 32'h1234); end
        idle(); c_sb_set = 1'b1; c_sb_wa = 4'd9;
        step();
        idle(); c_ra1 = 4'd9;
        step();
        n_cmp++; if (c_busy1 !== 1'b1) begin n_err++; $display("FAIL c_sb_set: got %b want 1", c_busy1); end
        c_we3 = 1'b1; c_wa3 = 4'd9; c_wd3 = 32'h99;
        step();
        idle();
        step();
        n_cmp++; if ({c_busy1, c_rd1} !== {1'b0, 32'h99}) begin n_err++; $display("FAIL c_sb_clr: got %b/%h want 0/99", c_busy1, c_rd1); end
        c_sb_set = 1'b1; c_sb_wa = 4'd4; c_we3 = 1'b1; c_wa3 = 4'd4; c_wd3 = 32'h44;
        step();
        c_wa3 = 4'd6; c_wd3 = 32'h66;
        step();
        idle(); c_ra1 = 4'd4; c_ra2 = 4'd6;
        step();
        n_cmp++; if ({c_busy1, c_busy2} !== 2'b10) begin n_err++; $display("FAIL c_coll_busy: got %b%b want 10", c_busy1, c_busy2); end
        c_sb_set = 1'b1; c_sb_wa = 4'd0; c_ra1 = 4'd0;
        step();
        idle();
        step();
        n_cmp++; if ({c_busy1, c_rd1} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL c_sb_zr: got %b/%h want 0/0", c_busy1, c_rd1); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_bypass();
        test_scoreboard();
        test_sb_collide();
        test_async_reset();
        test_param_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
